// File: rtl/led_mmio_if.sv
// Data-memory port of the RV32I pipeline as seen by a memory-mapped peripheral.
// The CPU drives the store/load request; the peripheral answers combinationally.
interface led_mmio_if;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        hit;

  // Single-cycle memory-stage port: no valid/ready. A load is the current
  // DataAdr with MemWrite low, answered in the same cycle; a store is
  // MemWrite high with hit high, taken at the next rising clk edge.
  modport master (
    output MemWrite,
    output DataAdr,
    output WriteData,
    input  ReadData,
    input  hit
  );

  modport slave (
    input  MemWrite,
    input  DataAdr,
    input  WriteData,
    output ReadData,
    output hit
  );
endinterface

// File: rtl/led_mmio.sv
// Memory-mapped LED peripheral: CTRL/PATTERN/DIV/STEPS in a 16-byte window,
// with a prescaled rotate (optionally bouncing) of the LED pattern.
module led_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0080,
  parameter logic [7:0]  PAT_RESET = 8'h01,
  parameter logic [23:0] DIV_RESET = 24'd4
) (
  input  logic       clk,
  input  logic       reset,
  led_mmio_if.slave  bus,
  output logic [7:0] led
);

  localparam logic [27:0] BASE_HI = BASE_ADDR[31:4];

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_PAT   = 2'd1;
  localparam logic [1:0] OFF_DIV   = 2'd2;
  localparam logic [1:0] OFF_STEPS = 2'd3;

  logic        en_q, dir_q, bnc_q;
  logic [7:0]  pat_q;
  logic [23:0] div_q;
  logic [23:0] cnt_q;
  logic [15:0] steps_q;

  logic        en_d, dir_d, bnc_d;
  logic [7:0]  pat_d;
  logic [23:0] div_d;
  logic [23:0] cnt_d;
  logic [15:0] steps_d;

  logic        hit_c;
  logic [1:0]  off;
  logic        wr_ctrl, wr_pat, wr_div;
  logic        tick_due, ctrl_stop, tick, rotate;
  logic [7:0]  pat_rot;
  logic [31:0] rdata;

  logic unused_bits;
  assign unused_bits = ^{bus.DataAdr[1:0], bus.WriteData[31:24]};

  assign hit_c = (bus.DataAdr[31:4] == BASE_HI);
  assign off   = bus.DataAdr[3:2];

  always_comb begin
    wr_ctrl   = bus.MemWrite && hit_c && (off == OFF_CTRL);
    wr_pat    = bus.MemWrite && hit_c && (off == OFF_PAT);
    wr_div    = bus.MemWrite && hit_c && (off == OFF_DIV);
    // A CTRL store clearing EN cancels a tick that would land on the same edge.
    ctrl_stop = wr_ctrl && !bus.WriteData[0];
    tick_due  = en_q && (cnt_q == div_q);
    tick      = tick_due && !ctrl_stop;
    // A PATTERN store overrides the rotation entirely (no step counted).
    rotate    = tick && !wr_pat;
    pat_rot   = dir_q ? {pat_q[0], pat_q[7:1]} : {pat_q[6:0], pat_q[7]};
  end

  // Next-state for the pattern, step counter and prescaler.
  always_comb begin
    pat_d   = pat_q;
    steps_d = steps_q;
    div_d   = div_q;
    cnt_d   = cnt_q;

    if (wr_pat) begin
      pat_d = bus.WriteData[7:0];
    end else if (rotate) begin
      pat_d = pat_rot;
    end

    if (rotate) begin
      steps_d = steps_q + 16'd1;
    end

    if (wr_div) begin
      div_d = bus.WriteData[23:0];
    end

    if (wr_pat || wr_div || !en_q || ctrl_stop) begin
      cnt_d = '0;
    end else if (tick_due) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Control bits: software store beats the hardware bounce of DIR.
  always_comb begin
    en_d  = en_q;
    dir_d = dir_q;
    bnc_d = bnc_q;

    if (wr_ctrl) begin
      en_d  = bus.WriteData[0];
      dir_d = bus.WriteData[1];
      bnc_d = bus.WriteData[2];
    end else if (rotate && bnc_q) begin
      if (!dir_q && pat_rot[7]) begin
        dir_d = 1'b1;
      end else if (dir_q && pat_rot[0]) begin
        dir_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      bnc_q   <= 1'b0;
      pat_q   <= PAT_RESET;
      div_q   <= DIV_RESET;
      cnt_q   <= '0;
      steps_q <= '0;
    end else begin
      en_q    <= en_d;
      dir_q   <= dir_d;
      bnc_q   <= bnc_d;
      pat_q   <= pat_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
    end
  end

  // Zero-latency readback, forced to zero outside the window so the load mux
  // in top can simply OR or select on hit.
  always_comb begin
    rdata = '0;
    unique case (off)
      OFF_CTRL:  rdata = {29'd0, bnc_q, dir_q, en_q};
      OFF_PAT:   rdata = {24'd0, pat_q};
      OFF_DIV:   rdata = {8'd0, div_q};
      OFF_STEPS: rdata = {16'd0, steps_q};
      default:   rdata = '0;
    endcase
    if (!hit_c) begin
      rdata = '0;
    end
  end

  assign bus.ReadData = rdata;
  assign bus.hit      = hit_c;
  assign led          = pat_q;

endmodule

// File: tb/tb_led_mmio.sv
// Bench for led_mmio: directed stores/loads, expected {hit,ReadData,led}
// queued by the driver and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_led_mmio;

  localparam int W = 41;

  logic clk;
  logic reset;
  logic [7:0] led;
  led_mmio_if bus ();

  led_mmio dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .led   (led)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic         chk_req;
  int           checks;
  int           errors;

  function automatic logic [W-1:0] mk(input logic h, input logic [31:0] rd, input logic [7:0] l);
    return {h, rd, l};
  endfunction

  always @(negedge clk) begin
    if (chk_req) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      string        nm;
      act = {bus.hit, bus.ReadData, led};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got hit=%0d rd=%h led=%h, want a queued expectation",
                 act[40], act[39:8], act[7:0]);
      end else begin
        exp = exp_q.pop_front();
        nm  = name_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL %s: got hit=%0d rd=%h led=%h, want hit=%0d rd=%h led=%h",
                   nm, act[40], act[39:8], act[7:0], exp[40], exp[39:8], exp[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.MemWrite  = 1'b1;
    bus.DataAdr   = addr;
    bus.WriteData = data;
    step();
    bus.MemWrite  = 1'b0;
    bus.WriteData = '0;
  endtask

  // Load addr this cycle; the monitor checks it at the following negedge.
  task automatic look(input string nm, input logic [31:0] addr, input logic [W-1:0] exp);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = addr;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    chk_req = 1'b1;
    step();
    chk_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] p;
    logic       d;
    int         n;
    checks        = 0;
    errors        = 0;
    chk_req       = 1'b0;
    reset         = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = '0;
    bus.WriteData = '0;
    #150;
    reset = 1'b1;
    step();

    // Reset values
    look("rst_ctrl",  32'h80, mk(1'b1, 32'd0, 8'h01));
    look("rst_div",   32'h88, mk(1'b1, 32'd4, 8'h01));
    look("rst_steps", 32'h8C, mk(1'b1, 32'd0, 8'h01));
    look("rst_pat",   32'h84, mk(1'b1, 32'd1, 8'h01));

    // Register write/readback and window decode
    store(32'h84, 32'd25);
    look("pat_wr",      32'h84, mk(1'b1, 32'd25, 8'h19));
    store(32'h64, 32'hFFFF_FFFF);
    look("miss_hit",    32'h64, mk(1'b0, 32'd0, 8'h19));
    look("miss_nochg",  32'h84, mk(1'b1, 32'd25, 8'h19));
    store(32'h8C, 32'h1234);
    look("steps_ro",    32'h8C, mk(1'b1, 32'd0, 8'h19));
    look("low_bits",    32'h87, mk(1'b1, 32'd25, 8'h19));
    store(32'h80, 32'hFFFF_FFF8);
    look("ctrl_upper0", 32'h80, mk(1'b1, 32'd0, 8'h19));
    store(32'h88, 32'hFFFF_FFFF);
    look("div_upper0",  32'h88, mk(1'b1, 32'h00FF_FFFF, 8'h19));

    // Left rotation, DIV=2: one step every 3 cycles
    store(32'h88, 32'd2);
    store(32'h84, 32'h01);
    store(32'h80, 32'h1);
    for (int k = 0; k < 25; k++) begin
      n = k / 3;
      p = 8'h01 << (n % 8);
      look($sformatf("rot_k%0d", k), 32'h8C, mk(1'b1, n, p));
    end
    store(32'h80, 32'h0);
    look("rot_stopped", 32'h8C, mk(1'b1, 32'd8, 8'h01));

    // Bounce with DIV=0: 01..80, 40..01, 02
    store(32'h88, 32'd0);
    store(32'h84, 32'h01);
    store(32'h80, 32'h5);
    for (int k = 0; k < 16; k++) begin
      if (k <= 7)       p = 8'h01 << k;
      else if (k <= 14) p = 8'h80 >> (k - 7);
      else              p = 8'h01 << (k - 14);
      d = (k >= 7) && (k < 14);
      look($sformatf("bnc_k%0d", k), 32'h80, mk(1'b1, d ? 32'd7 : 32'd5, p));
    end
    // EN=0 store lands on a tick edge: that tick is cancelled
    store(32'h80, 32'h0);
    look("en_off_steps", 32'h8C, mk(1'b1, 32'd24, 8'h04));
    look("en_off_ctrl",  32'h80, mk(1'b1, 32'd0, 8'h04));

    // PATTERN store on a tick edge wins
    store(32'h80, 32'h1);
    store(32'h84, 32'hAA);
    look("pat_win",  32'h8C, mk(1'b1, 32'd24, 8'hAA));
    look("pat_next", 32'h8C, mk(1'b1, 32'd25, 8'h55));

    // Asynchronous reset mid-rotation
    store(32'h80, 32'h0);
    store(32'h84, 32'h10);
    store(32'h88, 32'd3);
    store(32'h80, 32'h1);
    look("pre_reset", 32'h84, mk(1'b1, 32'h10, 8'h10));
    reset = 1'b0;
    look("async_rst", 32'h80, mk(1'b1, 32'd0, 8'h01));
    reset = 1'b1;
    look("post_ctrl",  32'h80, mk(1'b1, 32'd0, 8'h01));
    look("post_div",   32'h88, mk(1'b1, 32'd4, 8'h01));
    for (int k = 0; k < 6; k++) begin
      step();
    end
    look("post_halt",  32'h8C, mk(1'b1, 32'd0, 8'h01));

    step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
